// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and phase duration defaults for the
// two-road traffic phase scheduler.
package traffic_pkg;

   localparam logic [2:0] ST_ALLRED_A = 3'd0;
   localparam logic [2:0] ST_A_GRN    = 3'd1;
   localparam logic [2:0] ST_A_YEL    = 3'd2;
   localparam logic [2:0] ST_ALLRED_B = 3'd3;
   localparam logic [2:0] ST_B_GRN    = 3'd4;
   localparam logic [2:0] ST_B_YEL    = 3'd5;
   localparam logic [2:0] ST_WALK     = 3'd6;

   typedef enum logic [2:0] {
      StAllRedA = ST_ALLRED_A,
      StAGrn    = ST_A_GRN,
      StAYel    = ST_A_YEL,
      StAllRedB = ST_ALLRED_B,
      StBGrn    = ST_B_GRN,
      StBYel    = ST_B_YEL,
      StWalk    = ST_WALK
   } state_e;

   localparam logic [1:0] LIGHT_RED = 2'b00;
   localparam logic [1:0] LIGHT_YEL = 2'b01;
   localparam logic [1:0] LIGHT_GRN = 2'b10;

   localparam int unsigned GREEN_MIN_DEF = 10;
   localparam int unsigned GREEN_MAX_DEF = 30;
   localparam int unsigned YELLOW_T_DEF  = 3;
   localparam int unsigned ALLRED_T_DEF  = 1;
   localparam int unsigned WALK_T_DEF    = 8;
   localparam int unsigned CNT_W_DEF     = 6;

endpackage

// File: rtl/phase_timer.sv
// Phase tick counter: cleared on phase entry, advances on i_tick, holds while
// saturated, and flags when it sits on the supplied terminal value.
module phase_timer #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_clr,
   input  logic             i_tick,
   input  logic             i_sat,
   input  logic [CNT_W-1:0] i_term,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_at_term,
   output logic             o_expired
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_tick && !i_sat) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt     = cnt_q;
   assign o_at_term = (cnt_q == i_term);
   assign o_expired = i_tick && o_at_term;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic phase sequencer with pedestrian latch and emergency override.
// Defining PED_WALK_EN adds the pedestrian WALK phase; otherwise o_walk is tied low.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_MIN = GREEN_MIN_DEF,
   parameter int unsigned GREEN_MAX = GREEN_MAX_DEF,
   parameter int unsigned YELLOW_T  = YELLOW_T_DEF,
   parameter int unsigned ALLRED_T  = ALLRED_T_DEF,
   parameter int unsigned WALK_T    = WALK_T_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_tick,
   input  logic       i_req_a,
   input  logic       i_req_b,
   input  logic       i_ped,
   input  logic       i_emg,
   output logic [1:0] o_light_a,
   output logic [1:0] o_light_b,
   output logic       o_walk,
   output logic [2:0] o_state
);

`ifdef PED_WALK_EN
   localparam bit WalkEn = 1'b1;
`else
   localparam bit WalkEn = 1'b0;
`endif

   state_e           state_q, state_d;
   logic             ped_q, ped_d, ped_clr;
   logic             last_a_q, last_a_d;
   logic [CNT_W-1:0] cnt, term;
   logic             at_term, expired, entering, green_min_met;
   logic [1:0]       light_a_q, light_a_d, light_b_q, light_b_d;

   assign entering      = (state_d != state_q);
   assign green_min_met = (cnt >= CNT_W'(GREEN_MIN - 1));

   always_comb begin
      unique case (state_q)
         StAGrn, StBGrn: term = CNT_W'(GREEN_MAX - 1);
         StAYel, StBYel: term = CNT_W'(YELLOW_T - 1);
         StWalk:         term = CNT_W'(WALK_T - 1);
         default:        term = CNT_W'(ALLRED_T - 1);
      endcase
   end

   // Saturating at the terminal value keeps held phases (idle green, emergency
   // all-red) from wrapping, so they exit on the first qualifying tick.
   phase_timer #(
      .CNT_W (CNT_W)
   ) u_phase_timer (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_clr     (entering),
      .i_tick    (i_tick),
      .i_sat     (at_term),
      .i_term    (term),
      .o_cnt     (cnt),
      .o_at_term (at_term),
      .o_expired (expired)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StAGrn: begin
            if (i_emg || (i_tick && green_min_met && (i_req_b || ped_q))) state_d = StAYel;
         end
         StAYel: begin
            if (expired) state_d = StAllRedA;
         end
         StAllRedA: begin
            if (expired && !i_emg) state_d = (WalkEn && ped_q) ? StWalk : StBGrn;
         end
         StBGrn: begin
            if (i_emg || (i_tick && green_min_met && (i_req_a || ped_q))) state_d = StBYel;
         end
         StBYel: begin
            if (expired) state_d = StAllRedB;
         end
         StAllRedB: begin
            if (expired && !i_emg) state_d = (WalkEn && ped_q) ? StWalk : StAGrn;
         end
         StWalk: begin
            // Emergency truncates the walk into the all-red that preceded it.
            if (i_emg) begin
               state_d = last_a_q ? StAllRedA : StAllRedB;
            end else if (expired) begin
               state_d = last_a_q ? StBGrn : StAGrn;
            end
         end
         default: state_d = StAllRedB;
      endcase
   end

   always_comb begin
      last_a_d = last_a_q;
      if (state_d == StAGrn) last_a_d = 1'b1;
      if (state_d == StBGrn) last_a_d = 1'b0;
   end

`ifdef PED_WALK_EN
   assign ped_clr = entering && (state_d == StWalk);
`else
   assign ped_clr = entering && ((state_d == StAllRedA) || (state_d == StAllRedB));
`endif
   // A button press in the clearing cycle wins over the clear.
   assign ped_d = i_ped || (ped_q && !ped_clr);

   always_comb begin
      light_a_d = LIGHT_RED;
      light_b_d = LIGHT_RED;
      unique case (state_d)
         StAGrn:  light_a_d = LIGHT_GRN;
         StAYel:  light_a_d = LIGHT_YEL;
         StBGrn:  light_b_d = LIGHT_GRN;
         StBYel:  light_b_d = LIGHT_YEL;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= StAllRedB;
         ped_q     <= 1'b0;
         last_a_q  <= 1'b0;
         light_a_q <= LIGHT_RED;
         light_b_q <= LIGHT_RED;
      end else begin
         state_q   <= state_d;
         ped_q     <= ped_d;
         last_a_q  <= last_a_d;
         light_a_q <= light_a_d;
         light_b_q <= light_b_d;
      end
   end

`ifdef PED_WALK_EN
   logic walk_q;
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         walk_q <= 1'b0;
      end else begin
         walk_q <= (state_d == StWalk);
      end
   end
   assign o_walk = walk_q;
`else
   assign o_walk = 1'b0;
`endif

   assign o_light_a = light_a_q;
   assign o_light_b = light_b_q;
   assign o_state   = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Table-driven bench for traffic_phase_scheduler: each step holds inputs for a
// number of tick periods, then the queued expectation is checked.
module tb_traffic_phase_scheduler;

   localparam logic [1:0] RED = 2'b00;
   localparam logic [1:0] YEL = 2'b01;
   localparam logic [1:0] GRN = 2'b10;

   typedef struct {
      bit       rst;
      bit       req_a;
      bit       req_b;
      bit       ped;
      bit       emg;
      int       ticks;
      bit [2:0] st;
      bit [1:0] la;
      bit [1:0] lb;
      bit       walk;
   } step_t;

   logic       i_clk = 1'b0;
   logic       i_rstn, i_tick, i_req_a, i_req_b, i_ped, i_emg;
   logic [1:0] o_light_a, o_light_b;
   logic       o_walk;
   logic [2:0] o_state;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    viol    = 0;
   step_t steps[$];
   step_t exp_q[$];

   traffic_phase_scheduler dut (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_tick    (i_tick),
      .i_req_a   (i_req_a),
      .i_req_b   (i_req_b),
      .i_ped     (i_ped),
      .i_emg     (i_emg),
      .o_light_a (o_light_a),
      .o_light_b (o_light_b),
      .o_walk    (o_walk),
      .o_state   (o_state)
   );

   always #5 i_clk = ~i_clk;

   // Both roads non-RED together, or the unused 11 code, is a safety violation.
   always @(negedge i_clk) begin
      if (i_rstn === 1'b1) begin
         if (o_light_a !== RED && o_light_b !== RED) viol++;
         if (o_light_a === 2'b11 || o_light_b === 2'b11) viol++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input bit rst, input bit a, input bit b, input bit p,
                               input bit e, input int t, input bit [2:0] st);
      step_t s;
      s.rst   = rst;
      s.req_a = a;
      s.req_b = b;
      s.ped   = p;
      s.emg   = e;
      s.ticks = t;
      s.st    = st;
      s.la    = (st == 3'd1) ? GRN : (st == 3'd2) ? YEL : RED;
      s.lb    = (st == 3'd4) ? GRN : (st == 3'd5) ? YEL : RED;
      s.walk  = (st == 3'd6);
      steps.push_back(s);
   endfunction

   task automatic run_step(input step_t s, input int idx);
      step_t e;
      exp_q.push_back(s);
      if (s.rst) begin
         i_rstn = 1'b0;
         @(negedge i_clk);
         i_rstn = 1'b1;
      end
      i_req_a = s.req_a;
      i_req_b = s.req_b;
      i_emg   = s.emg;
      if (s.ticks == 0) begin
         i_ped = s.ped;
         @(negedge i_clk);
         i_ped = 1'b0;
      end else begin
         for (int k = 0; k < s.ticks; k++) begin
            i_tick = 1'b1;
            i_ped  = (k == 0) ? s.ped : 1'b0;
            @(negedge i_clk);
            i_tick = 1'b0;
            i_ped  = 1'b0;
            @(negedge i_clk);
         end
      end
      e = exp_q.pop_front();
      chk($sformatf("step%0d {state,la,lb,walk}", idx),
          {24'd0, o_state, o_light_a, o_light_b, o_walk},
          {24'd0, e.st, e.la, e.lb, e.walk});
   endtask

   initial begin
      i_rstn  = 1'b0;
      i_tick  = 1'b0;
      i_req_a = 1'b0;
      i_req_b = 1'b0;
      i_ped   = 1'b0;
      i_emg   = 1'b0;
      @(negedge i_clk);
      chk("reset_state", {29'd0, o_state}, 32'd3);
      chk("reset_light_a", {30'd0, o_light_a}, {30'd0, RED});
      chk("reset_light_b", {30'd0, o_light_b}, {30'd0, RED});
      chk("reset_walk", {31'd0, o_walk}, 32'd0);

      //  rst a  b  p  e  ticks state
      add(1, 1, 0, 0, 0, 0,  3'd3);  // ALLRED_B after reset
      add(0, 1, 0, 0, 0, 1,  3'd1);  // one all-red tick, then A green
      add(0, 1, 0, 0, 0, 50, 3'd1);  // no competitor: hold
      add(1, 1, 0, 0, 0, 0,  3'd3);
      add(0, 1, 0, 0, 0, 1,  3'd1);
      add(0, 1, 0, 0, 0, 2,  3'd1);
      add(0, 1, 1, 0, 0, 7,  3'd1);  // 9 ticks of green so far
      add(0, 1, 1, 0, 0, 1,  3'd2);  // 10th tick ends green
      add(0, 1, 1, 0, 0, 2,  3'd2);
      add(0, 1, 1, 0, 0, 1,  3'd0);
      add(0, 1, 1, 0, 0, 1,  3'd4);
      add(0, 1, 1, 0, 0, 9,  3'd4);
      add(0, 1, 1, 0, 0, 1,  3'd5);
      add(0, 1, 1, 0, 0, 3,  3'd3);
      add(0, 1, 1, 0, 0, 1,  3'd1);
      add(0, 1, 1, 0, 0, 9,  3'd1);
      add(0, 1, 1, 0, 0, 1,  3'd2);
      add(0, 1, 1, 0, 0, 3,  3'd0);
      add(0, 1, 1, 0, 0, 1,  3'd4);
      add(0, 1, 0, 0, 0, 10, 3'd5);
      add(0, 1, 0, 0, 0, 3,  3'd3);
      add(0, 1, 0, 0, 0, 1,  3'd1);
      add(0, 0, 0, 0, 0, 4,  3'd1);
      add(0, 0, 0, 0, 1, 0,  3'd2);  // emergency: yellow next cycle, no tick needed
      add(0, 0, 0, 0, 1, 3,  3'd0);
      add(0, 0, 0, 0, 1, 5,  3'd0);  // all-red held under emergency
      add(0, 0, 0, 0, 0, 0,  3'd0);
      add(0, 0, 0, 0, 0, 1,  3'd4);  // resume with B
`ifdef PED_WALK_EN
      add(0, 0, 0, 1, 0, 10, 3'd5);  // ped ends B green at GREEN_MIN
      add(0, 0, 0, 0, 0, 3,  3'd3);
      add(0, 0, 0, 1, 0, 1,  3'd6);  // second press in the walk entry cycle
      add(0, 0, 0, 0, 0, 7,  3'd6);
      add(0, 0, 0, 0, 0, 1,  3'd1);
      add(0, 0, 0, 0, 0, 9,  3'd1);
      add(0, 0, 0, 0, 0, 1,  3'd2);  // still-pending ped ends A green
      add(0, 0, 0, 0, 0, 3,  3'd0);
      add(0, 0, 0, 0, 0, 1,  3'd6);
      add(0, 0, 0, 0, 0, 8,  3'd4);
      add(0, 1, 0, 0, 0, 10, 3'd5);
      add(0, 1, 0, 0, 0, 1,  3'd5);
`else
      add(0, 0, 0, 1, 0, 10, 3'd5);  // ped ends B green at GREEN_MIN
      add(0, 0, 0, 0, 0, 3,  3'd3);
      add(0, 0, 0, 0, 0, 1,  3'd1);
      add(0, 0, 0, 0, 0, 15, 3'd1);  // ped cleared at all-red: A holds
      add(0, 0, 1, 0, 0, 1,  3'd2);
      add(0, 0, 1, 0, 0, 3,  3'd0);
      add(0, 0, 1, 0, 0, 1,  3'd4);
      add(0, 1, 0, 0, 0, 10, 3'd5);
      add(0, 1, 0, 0, 0, 1,  3'd5);
`endif

      foreach (steps[i]) run_step(steps[i], i);

      // Asynchronous reset in the middle of B yellow.
      #2 i_rstn = 1'b0;
      #1;
      chk("async_rst_state", {29'd0, o_state}, 32'd3);
      chk("async_rst_light_a", {30'd0, o_light_a}, {30'd0, RED});
      chk("async_rst_light_b", {30'd0, o_light_b}, {30'd0, RED});
      chk("async_rst_walk", {31'd0, o_walk}, 32'd0);
      @(negedge i_clk);
      i_rstn  = 1'b1;
      i_req_a = 1'b1;
      i_req_b = 1'b0;
      i_tick  = 1'b1;
      @(negedge i_clk);
      i_tick = 1'b0;
      @(negedge i_clk);
      chk("post_reset_a_grn", {29'd0, o_state}, 32'd1);

      chk("safety_invariant_violations", viol, 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
